imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, registered immediate-generation stage for the MIPS datapath.
//  It takes an IN_W-bit instruction immediate plus a mode and produces an OUT_W-bit operand.
//  Four modes: zero-extend, sign-extend, upper-load placement and branch offset.
//  Sits between decode and execute. Uses valid/ready handshakes on both sides with
//  a 2-entry skid buffer, so it sustains full throughput under back-pressure.
// PARAMETERS
//  IN_W   16  immediate input width (>=2)
//  OUT_W  32  extended output width; must be >= IN_W (elaboration $error otherwise)
//  TAG_W  5   width of sideband tag (destination register id) carried with each item
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst_n       in   1      synchronous, active-low reset
//  in_valid    in   1      upstream item present
//  in_ready    out  1      block can accept an item this cycle
//  in_imm      in   IN_W   raw immediate
//  in_mode     in   2      00 zero-ext, 01 sign-ext, 10 upper, 11 branch offset
//  in_tag      in   TAG_W  sideband, passed through unchanged
//  out_valid   out  1      head entry valid
//  out_ready   in   1      downstream accepts head this cycle
//  out_data    out  OUT_W  extended immediate of head entry
//  out_tag     out  TAG_W  tag of head entry
//  xfer_count  out  16     accepted-input counter (only with IMMX_COUNT_EN)
// BEHAVIOUR
//  Transfer rules: push = in_valid & in_ready; pop = out_valid & out_ready, evaluated per edge.
//  Arithmetic, computed combinationally at input and stored already extended:
//   00: {(OUT_W-IN_W){1'b0}, imm}
//   01: {(OUT_W-IN_W){imm[IN_W-1]}, imm}
//   10: imm << (OUT_W-IN_W), low bits zero; when OUT_W==IN_W the result is imm
//   11: sign_ext(imm) << 2, truncated to OUT_W (upper bits lost, no flag)
//  Storage: 2-entry FIFO, with a count register cnt in {0,1,2} acting as states EMPTY/ONE/FULL.
//   EMPTY: push -> ONE. No push -> EMPTY. A pop cannot happen (out_valid=0).
//   ONE:   push only -> FULL; pop only -> EMPTY; push and pop together -> ONE,
//          and the new item becomes head on the next cycle.
//   FULL:  in_ready=0, so no push. Pop -> ONE, and the second entry becomes head.
//  in_ready = rst_n & (cnt!=2); out_valid = (cnt!=0). Both decode registered state only,
//   so there is no combinational path from out_ready to in_ready.
//  Latency: an item pushed at edge k is visible on out_* after edge k (1 cycle). Order is strict FIFO.
//  out_data and out_tag are stable while out_valid=1 and out_ready=0.
//  in_mode, in_imm and in_tag are sampled only on a push. Other values are don't-care.
//  Reset (rst_n=0 at an edge): cnt=0, out_valid=0, out_data=0, out_tag=0, storage zeroed,
//   xfer_count=0. in_ready is 0 for as long as rst_n is low.
//   Reset mid-operation drops all held items. No output from before reset reappears.
// CONFIGURATION
//  IMMX_COUNT_EN defined: xfer_count increments by 1 on every push and wraps
//   0xFFFF -> 0x0000. Pops do not affect it.
//  IMMX_COUNT_EN undefined: the xfer_count port and its counter logic are absent.
//   All other behaviour is identical.
// TESTING
//  T1 reset: hold rst_n=0 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0; no push counted.
//  T2 modes (16->32): imm=16'h8004 pushed with mode 00/01/10/11 -> out_data=32'h00008004 /
//     32'hFFFF8004 / 32'h80040000 / 32'hFFFE0010, each after 1 cycle, with tags 1..4 in order.
//  T3 back-pressure: out_ready=0, push A,B -> in_ready=0 after 2nd push, out_data=A stable;
//     raise out_ready -> A then B popped on consecutive cycles; in_ready returns 1 one cycle after first pop.
//  T4 simultaneous: cnt=1 (head A), push C while popping A -> next cycle out_data=C, cnt=1, no loss or duplication.
//  T5 reset mid-flight: cnt=2, assert rst_n=0 one edge -> out_valid=0, then push D -> first output is D.
//  T6 (IMMX_COUNT_EN): 65537 pushes from reset -> xfer_count=1; build without macro compiles, T1-T5 still pass.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered MIPS immediate extender with a 2-entry valid/ready skid FIFO.
// Define IMMX_COUNT_EN to add the 16-bit accepted-input counter port xfer_count.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef IMMX_COUNT_EN
  ,
  output logic [15:0]      xfer_count
`endif
);
  if (OUT_W < IN_W || IN_W < 2) begin : g_bad_width
    $error("imm_extend_pipe: need IN_W >= 2 and OUT_W >= IN_W");
  end
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_e;
  cnt_e             cnt_q;
  logic [OUT_W-1:0] data_q [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic [OUT_W-1:0] zx, sx, data_d;
  logic             push, pop;
  assign in_ready  = rst_n & (cnt_q != FULL);
  assign out_valid = cnt_q != EMPTY;
  assign out_data  = data_q[0];
  assign out_tag   = tag_q[0];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign zx        = OUT_W'(in_imm);
  assign sx        = OUT_W'($signed(in_imm));
  assign data_d    = in_mode == 2'd0 ? zx :
                     in_mode == 2'd1 ? sx :
                     in_mode == 2'd2 ? zx << (OUT_W - IN_W) : sx << 2;
  // Entry 0 is always the head; entry 1 only holds the second item while FULL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= EMPTY;
      data_q[0] <= '0;
      data_q[1] <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
    end else begin
      case (cnt_q)
        EMPTY: if (push) begin
          cnt_q     <= ONE;
          data_q[0] <= data_d;
          tag_q[0]  <= in_tag;
        end
        ONE: if (push && pop) begin
          data_q[0] <= data_d;
          tag_q[0]  <= in_tag;
        end else if (push) begin
          cnt_q     <= FULL;
          data_q[1] <= data_d;
          tag_q[1]  <= in_tag;
        end else if (pop) begin
          cnt_q <= EMPTY;
        end
        FULL: if (pop) begin
          cnt_q     <= ONE;
          data_q[0] <= data_q[1];
          tag_q[0]  <= tag_q[1];
        end
        default: cnt_q <= EMPTY;
      endcase
    end
  end
`ifdef IMMX_COUNT_EN
  logic [15:0] xfer_q;
  assign xfer_count = xfer_q;
  always_ff @(posedge clk) begin
    if (!rst_n) xfer_q <= '0;
    else if (push) xfer_q <= xfer_q + 16'd1;
  end
`endif
endmodule
